// File: rtl/udp_rx_pkt_buffer_if.sv
// Bus bundle between the UDP receiver, the packet buffer and the loopback transmitter.
// The slave modport is the buffer's view; the master modport is the surrounding logic's view.
interface udp_rx_pkt_buffer_if;
  // receive side
  logic        payload_valid_i;
  logic [7:0]  payload_data_i;
  logic [15:0] rx_data_len_i;
  logic        one_pkt_done_i;
  logic        pkt_err_i;
  logic [47:0] exter_mac_i;
  logic [31:0] exter_ip_i;
  logic [15:0] exter_port_i;
  logic        data_overflow_o;
  // transmit side
  logic        pkt_avail_o;
  logic [15:0] pkt_len_o;
  logic [47:0] pkt_mac_o;
  logic [31:0] pkt_ip_o;
  logic [15:0] pkt_port_o;
  logic        rd_en_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic [15:0] drop_cnt_o;

  modport slave (
    input  payload_valid_i, payload_data_i, rx_data_len_i, one_pkt_done_i, pkt_err_i,
    input  exter_mac_i, exter_ip_i, exter_port_i, rd_en_i,
    output data_overflow_o, pkt_avail_o, pkt_len_o, pkt_mac_o, pkt_ip_o, pkt_port_o,
    output rd_data_o, rd_valid_o, drop_cnt_o
  );

  modport master (
    output payload_valid_i, payload_data_i, rx_data_len_i, one_pkt_done_i, pkt_err_i,
    output exter_mac_i, exter_ip_i, exter_port_i, rd_en_i,
    input  data_overflow_o, pkt_avail_o, pkt_len_o, pkt_mac_o, pkt_ip_o, pkt_port_o,
    input  rd_data_o, rd_valid_o, drop_cnt_o
  );
endinterface

// File: rtl/udp_rx_pkt_buffer.sv
// UDP receive packet buffer: payload bytes go into a circular RAM and are committed or rolled
// back when the packet ends; committed packets are described by a small metadata FIFO and
// drained byte by byte by the loopback transmitter.
module udp_rx_pkt_buffer #(
  parameter int ADDR_W  = 11,
  parameter int META_AW = 2
) (
  input logic                clk_125m,
  input logic                rst,
  udp_rx_pkt_buffer_if.slave bus
);
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int META_DEPTH = 1 << META_AW;
  localparam logic [ADDR_W:0]  RAM_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [META_AW:0] META_FULL = {1'b1, {META_AW{1'b0}}};

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_RECV = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  logic [7:0]  ram        [DEPTH];
  logic [15:0] meta_len_q [META_DEPTH];
  logic [47:0] meta_mac_q [META_DEPTH];
  logic [31:0] meta_ip_q  [META_DEPTH];
  logic [15:0] meta_port_q[META_DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [15:0]       byte_cnt_q, byte_cnt_d, drop_cnt_q, drop_cnt_d, rd_cnt_q;
  logic              ovf_q, ovf_d, done_q, err_q;
  logic [META_AW:0]  meta_wr_q, meta_rd_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;

  logic [ADDR_W:0]   used;
  logic              ram_full, byte_wr, meta_empty, meta_full, commit, rd_accept, rd_last;
  logic [15:0]       head_len;

  assign used       = wr_ptr_q - rd_ptr_q;
  assign ram_full   = (used == RAM_FULL);
  assign meta_empty = (meta_wr_q == meta_rd_q);
  assign meta_full  = ((meta_wr_q - meta_rd_q) == META_FULL);

  // The resolve cycle (done_q) owns the write pointer, so a byte arriving then is not stored.
  assign byte_wr = bus.payload_valid_i && !done_q && (state_q != W_DROP) && !ram_full;

  assign commit = done_q && !err_q && (state_q != W_DROP) &&
                  (byte_cnt_q == bus.rx_data_len_i) && (byte_cnt_q != 16'd0) && !meta_full;

  assign head_len  = meta_len_q[meta_rd_q[META_AW-1:0]];
  assign rd_accept = bus.rd_en_i && !meta_empty && (rd_cnt_q < head_len);
  assign rd_last   = rd_accept && (rd_cnt_q == head_len - 16'd1);

  // Write-side next state: byte acceptance, overflow detection and commit/rollback on resolve.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    drop_cnt_d   = drop_cnt_q;
    if (done_q) begin
      state_d    = W_IDLE;
      byte_cnt_d = 16'd0;
      ovf_d      = 1'b0;
      if (commit) begin
        commit_ptr_d = wr_ptr_q;
      end else begin
        wr_ptr_d = commit_ptr_q;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (bus.payload_valid_i) begin
      case (state_q)
        W_IDLE, W_RECV: begin
          if (ram_full) begin
            state_d = W_DROP;
            ovf_d   = 1'b1;
          end else begin
            state_d    = W_RECV;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            byte_cnt_d = byte_cnt_q + 16'd1;
          end
        end
        W_DROP:  state_d = W_DROP;
        default: state_d = W_IDLE;
      endcase
    end
  end

  // Control registers for both the write and read sides.
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      meta_wr_q    <= '0;
      meta_rd_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
      done_q       <= bus.one_pkt_done_i;
      if (bus.one_pkt_done_i) err_q <= bus.pkt_err_i;
      if (commit) meta_wr_q <= meta_wr_q + 1'b1;
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_cnt_q <= rd_last ? 16'd0 : rd_cnt_q + 16'd1;
      end
      if (rd_last) meta_rd_q <= meta_rd_q + 1'b1;
    end
  end

  // Payload RAM write port.
  always_ff @(posedge clk_125m) begin
    if (byte_wr) ram[wr_ptr_q[ADDR_W-1:0]] <= bus.payload_data_i;
  end

  // Payload RAM registered read port.
  always_ff @(posedge clk_125m) begin
    if (rst) rd_data_q <= 8'd0;
    else if (rd_accept) rd_data_q <= ram[rd_ptr_q[ADDR_W-1:0]];
  end

  // Metadata FIFO storage; the source address is captured in the resolve cycle.
  always_ff @(posedge clk_125m) begin
    if (commit) begin
      meta_len_q[meta_wr_q[META_AW-1:0]]  <= byte_cnt_q;
      meta_mac_q[meta_wr_q[META_AW-1:0]]  <= bus.exter_mac_i;
      meta_ip_q[meta_wr_q[META_AW-1:0]]   <= bus.exter_ip_i;
      meta_port_q[meta_wr_q[META_AW-1:0]] <= bus.exter_port_i;
    end
  end

  assign bus.data_overflow_o = ovf_q;
  assign bus.pkt_avail_o     = !meta_empty;
  assign bus.pkt_len_o       = meta_empty ? 16'd0 : head_len;
  assign bus.pkt_mac_o       = meta_empty ? 48'd0 : meta_mac_q[meta_rd_q[META_AW-1:0]];
  assign bus.pkt_ip_o        = meta_empty ? 32'd0 : meta_ip_q[meta_rd_q[META_AW-1:0]];
  assign bus.pkt_port_o      = meta_empty ? 16'd0 : meta_port_q[meta_rd_q[META_AW-1:0]];
  assign bus.rd_data_o       = rd_data_q;
  assign bus.rd_valid_o      = rd_valid_q;
  assign bus.drop_cnt_o      = drop_cnt_q;
endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Randomised bench for udp_rx_pkt_buffer against a queue-based packet model.
module tb_udp_rx_pkt_buffer;
  localparam int DEPTH = 2048;
  localparam int META_DEPTH = 4;

  logic clk_125m = 1'b0;
  logic rst = 1'b1;
  always #4 clk_125m = ~clk_125m;

  udp_rx_pkt_buffer_if bus();
  udp_rx_pkt_buffer #(.ADDR_W(11), .META_AW(2)) dut (
    .clk_125m(clk_125m),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    int          len;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } meta_t;

  // reference model: committed packet descriptors, committed-unread bytes, current packet bytes
  meta_t      meta_q[$];
  logic [7:0] data_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] tx_q[$];
  bit         m_drop;
  int         m_drops;
  int         m_rd_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_125m);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".avail"}, 64'(bus.pkt_avail_o), 64'(meta_q.size() != 0));
    if (meta_q.size() != 0) begin
      check({tag, ".len"},  64'(bus.pkt_len_o),  64'(meta_q[0].len));
      check({tag, ".mac"},  64'(bus.pkt_mac_o),  64'(meta_q[0].mac));
      check({tag, ".ip"},   64'(bus.pkt_ip_o),   64'(meta_q[0].ip));
      check({tag, ".port"}, 64'(bus.pkt_port_o), 64'(meta_q[0].port));
    end else begin
      check({tag, ".len0"}, 64'(bus.pkt_len_o), 64'd0);
    end
    check({tag, ".drops"}, 64'(bus.drop_cnt_o), 64'(m_drops));
    check({tag, ".ovf"},   64'(bus.data_overflow_o), 64'(m_drop));
  endtask

  task automatic check_reset;
    check("rst.avail", 64'(bus.pkt_avail_o), 64'd0);
    check("rst.len",   64'(bus.pkt_len_o), 64'd0);
    check("rst.mac",   64'(bus.pkt_mac_o), 64'd0);
    check("rst.ip",    64'(bus.pkt_ip_o), 64'd0);
    check("rst.port",  64'(bus.pkt_port_o), 64'd0);
    check("rst.rdv",   64'(bus.rd_valid_o), 64'd0);
    check("rst.rdd",   64'(bus.rd_data_o), 64'd0);
    check("rst.ovf",   64'(bus.data_overflow_o), 64'd0);
    check("rst.drops", 64'(bus.drop_cnt_o), 64'd0);
  endtask

  task automatic fill_bytes(input int n, input bit rnd, input logic [7:0] base);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(base + 8'(i)));
  endtask

  // Sends tx_q as one packet, pulses done, presents metadata the cycle after, applies model rules.
  task automatic send_pkt(input int len_field, input bit err, input logic [47:0] mac,
                          input logic [31:0] ip, input logic [15:0] port);
    bit ok;
    bus.rx_data_len_i = 16'(len_field);
    foreach (tx_q[i]) begin
      bus.payload_valid_i = 1'b1;
      bus.payload_data_i  = tx_q[i];
      tick;
      if (!m_drop) begin
        if (data_q.size() + pend_q.size() >= DEPTH) m_drop = 1'b1;
        else pend_q.push_back(tx_q[i]);
      end
      check("byte.ovf", 64'(bus.data_overflow_o), 64'(m_drop));
    end
    bus.payload_valid_i = 1'b0;
    bus.payload_data_i  = 8'($urandom);
    bus.one_pkt_done_i  = 1'b1;
    bus.pkt_err_i       = err;
    bus.exter_mac_i     = {$urandom, $urandom};
    bus.exter_ip_i      = $urandom;
    bus.exter_port_i    = 16'($urandom);
    tick;
    bus.one_pkt_done_i  = 1'b0;
    bus.pkt_err_i       = 1'($urandom);
    bus.exter_mac_i     = mac;
    bus.exter_ip_i      = ip;
    bus.exter_port_i    = port;
    tick;
    bus.exter_mac_i     = {$urandom, $urandom};
    bus.exter_ip_i      = $urandom;
    bus.exter_port_i    = 16'($urandom);
    ok = !err && !m_drop && (pend_q.size() == len_field) && (len_field != 0) &&
         (meta_q.size() < META_DEPTH);
    if (ok) begin
      meta_q.push_back('{len: len_field, mac: mac, ip: ip, port: port});
      foreach (pend_q[i]) data_q.push_back(pend_q[i]);
    end else if (m_drops < 65535) begin
      m_drops++;
    end
    $display("pkt sent=%0d len=%0d err=%0d mac=%012h -> %s", tx_q.size(), len_field, err, mac,
             ok ? "commit" : "discard");
    pend_q.delete();
    m_drop = 1'b0;
    check_state("pkt");
  endtask

  // Reads up to nbytes accepted bytes (stops when nothing is committed) with random rd_en gaps.
  task automatic read_n(input int nbytes);
    int got = 0;
    int guard = 0;
    bit en, acc;
    logic [7:0] exp_b;
    while (got < nbytes && meta_q.size() != 0 && guard < 20000) begin
      guard++;
      en = ($urandom_range(0, 3) != 0);
      bus.rd_en_i = en;
      acc = en && (meta_q.size() != 0);
      exp_b = 8'd0;
      if (acc) begin
        exp_b = data_q.pop_front();
        m_rd_cnt++;
        got++;
        if (m_rd_cnt == meta_q[0].len) begin
          void'(meta_q.pop_front());
          m_rd_cnt = 0;
        end
      end
      tick;
      check("rd.valid", 64'(bus.rd_valid_o), 64'(acc));
      if (acc) check("rd.data", 64'(bus.rd_data_o), 64'(exp_b));
      check("rd.avail", 64'(bus.pkt_avail_o), 64'(meta_q.size() != 0));
      if (meta_q.size() != 0) check("rd.len", 64'(bus.pkt_len_o), 64'(meta_q[0].len));
    end
    bus.rd_en_i = 1'b0;
    if (guard >= 20000) check("rd.timeout", 64'd1, 64'd0);
    $display("read %0d bytes, %0d packets still queued", got, meta_q.size());
  endtask

  task automatic idle_read;
    bus.rd_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle.rdv", 64'(bus.rd_valid_o), 64'd0);
    end
    bus.rd_en_i = 1'b0;
  endtask

  task automatic model_reset;
    meta_q.delete();
    data_q.delete();
    pend_q.delete();
    m_drop = 1'b0;
    m_drops = 0;
    m_rd_cnt = 0;
  endtask

  initial begin
    int nb, lf;
    bus.payload_valid_i = 1'b0;
    bus.payload_data_i  = 8'd0;
    bus.rx_data_len_i   = 16'd0;
    bus.one_pkt_done_i  = 1'b0;
    bus.pkt_err_i       = 1'b0;
    bus.exter_mac_i     = 48'd0;
    bus.exter_ip_i      = 32'd0;
    bus.exter_port_i    = 16'd0;
    bus.rd_en_i         = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) tick;
    check_reset();
    rst = 1'b0;
    tick;

    // 18-byte packet, read back
    fill_bytes(18, 1'b0, 8'h00);
    send_pkt(18, 1'b0, 48'h112233445566, 32'hC0A80001, 16'd1234);
    check("t1.len", 64'(bus.pkt_len_o), 64'd18);
    read_n(100000);
    check("t1.empty", 64'(bus.pkt_avail_o), 64'd0);
    idle_read();

    // errored packet discarded, then a clean 10-byte packet
    fill_bytes(18, 1'b0, 8'h00);
    send_pkt(18, 1'b1, 48'h112233445566, 32'hC0A80001, 16'd1234);
    check("t2.drops", 64'(bus.drop_cnt_o), 64'd1);
    fill_bytes(10, 1'b1, 8'h00);
    send_pkt(10, 1'b0, 48'hA1A2A3A4A5A6, 32'h0A000002, 16'd80);
    read_n(100000);

    // short packet (19 of 20) and done with no bytes both discarded
    fill_bytes(19, 1'b1, 8'h00);
    send_pkt(20, 1'b0, 48'h1, 32'h1, 16'h1);
    fill_bytes(0, 1'b1, 8'h00);
    send_pkt(5, 1'b0, 48'h2, 32'h2, 16'h2);
    check("t4.drops", 64'(bus.drop_cnt_o), 64'd3);

    // large packet fills RAM, following packet overflows after byte 9
    fill_bytes(2040, 1'b1, 8'h00);
    send_pkt(2040, 1'b0, 48'hBEEF00000001, 32'h01020304, 16'd7);
    fill_bytes(100, 1'b1, 8'h00);
    send_pkt(100, 1'b0, 48'hBEEF00000002, 32'h01020305, 16'd8);
    check("t3.drops", 64'(bus.drop_cnt_o), 64'd4);
    check("t3.head", 64'(bus.pkt_len_o), 64'd2040);
    read_n(100000);

    // metadata FIFO full: packets 1..4 commit, 5 dropped, read one, 6 commits
    for (int p = 1; p <= 6; p++) begin
      if (p == 6) read_n(meta_q[0].len);
      fill_bytes(8 + p, 1'b1, 8'h00);
      send_pkt(8 + p, 1'b0, 48'(p), 32'(p), 16'(p));
    end
    check("t5.head", 64'(bus.pkt_mac_o), 64'd2);
    check("t5.count", 64'(meta_q.size()), 64'd4);
    read_n(100000);

    // random traffic wrapping the RAM several times
    for (int it = 0; it < 30; it++) begin
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(600, 1100) : $urandom_range(0, 300);
      lf = nb;
      if ($urandom_range(0, 9) == 0) lf = nb + 1;
      fill_bytes(nb, 1'b1, 8'h00);
      send_pkt(lf, $urandom_range(0, 7) == 0, {$urandom, $urandom}, $urandom, 16'($urandom));
      if ($urandom_range(0, 1) == 0) read_n($urandom_range(1, 1500));
    end
    read_n(100000);

    // reset mid-read and mid-packet
    fill_bytes(30, 1'b0, 8'hA5);
    send_pkt(30, 1'b0, 48'hCAFE, 32'hCAFE, 16'hCAFE);
    read_n(3);
    bus.rx_data_len_i = 16'd50;
    for (int i = 0; i < 20; i++) begin
      bus.payload_valid_i = 1'b1;
      bus.payload_data_i  = 8'(i + 1);
      tick;
    end
    bus.payload_valid_i = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    model_reset();
    check_reset();
    rst = 1'b0;
    tick;
    fill_bytes(25, 1'b1, 8'h00);
    send_pkt(25, 1'b0, 48'hD00D, 32'hD00D, 16'hD00D);
    read_n(100000);
    idle_read();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
